ysyx_22051013_csr_trap: RTL and testbench

Next-generation machine-mode CSR file plus trap/interrupt controller for the single-issue core. It adds to the existing CSR set (mstatus/mtvec/mepc/mcause):
- mie, mip, mscratch, mtval, mcycle, minstret;
- set/clear CSR ops;
- vectored mtvec;
- prioritised timer/software/external interrupts.

It sits beside the EXU/WB boundary. It supplies the trap/mret redirect PC to the IFU and the CSR read data to WB.

---
 rtl/ysyx_22051013_csr_trap_pkg.sv | 39 +++
 rtl/ysyx_22051013_irq_sync.sv | 22 ++
 rtl/ysyx_22051013_csr_trap.sv | 197 +++++++++++++++++++
 tb/tb_ysyx_22051013_csr_trap.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22051013_csr_trap_pkg.sv
// Shared constants for the machine-mode CSR file and trap controller:
// CSR addresses, CSR op encodings, trap cause codes, mstatus bit positions
// and the implemented interrupt-bit mask.
package ysyx_22051013_csr_trap_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;
  localparam logic [3:0] CAUSE_MSI     = 4'd3;
  localparam logic [3:0] CAUSE_MTI     = 4'd7;
  localparam logic [3:0] CAUSE_MEI     = 4'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // MSIP (3), MTIP (7) and MEIP (11) are the only implemented mie/mip bits.
  localparam logic [11:0] IRQ_MASK = 12'h888;

endpackage

// File: rtl/ysyx_22051013_irq_sync.sv
// Two-flop synchroniser for an asynchronous level interrupt source.
module ysyx_22051013_irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_p1;

  // Shift the raw level through two flops before anyone looks at it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_p1 <= 1'b0;
      q       <= 1'b0;
    end else begin
      meta_p1 <= d;
      q       <= meta_p1;
    end
  end

endmodule

// File: rtl/ysyx_22051013_csr_trap.sv
// Machine-mode CSR file and trap/interrupt controller. Sits at the EXU/WB
// boundary: returns old CSR values to WB, commits CSR writes at posedge and
// redirects the IFU on exceptions, interrupts and mret.
module ysyx_22051013_csr_trap
  import ysyx_22051013_csr_trap_pkg::*;
#(
  parameter int          XLEN         = 64,
  parameter logic [63:0] RST_MTVEC    = 64'h0,
  parameter bit          HAS_COUNTERS = 1'b1,
  parameter bit          VECTORED_EN  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            exc_ecall,
  input  logic            exc_ebreak,
  input  logic            exc_illegal,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret,
  input  logic [XLEN-1:0] pc,
  input  logic            int_ready,
  input  logic            instr_retire,
  input  logic            irq_timer,
  input  logic            irq_soft,
  input  logic            irq_ext,
  output logic            trap_valid,
  output logic [XLEN-1:0] trap_pc
);

  localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] LOW2_CLR = ~{{(XLEN-2){1'b0}}, 2'b11};
  localparam logic [XLEN-1:0] MTVEC_RST_VAL =
    VECTORED_EN ? RST_MTVEC[XLEN-1:0] : (RST_MTVEC[XLEN-1:0] & LOW2_CLR);

  csr_op_e         op;
  logic            mstatus_mie, mstatus_mpie;
  logic [11:0]     mie_q, mip, irq_pend;
  logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0] mcycle_q, minstret_q;
  logic [XLEN-1:0] mstatus_rd, csr_old, csr_new;
  logic            csr_hit, csr_wen;
  logic            irq_timer_p1, irq_soft_p1, irq_ext_p2;
  logic            exc_any, irq_take, trap;
  logic [3:0]      exc_cause, irq_cause;
  logic [XLEN-1:0] trap_base, trap_vec, mcause_new;

  assign op = csr_op_e'(csr_op);

  ysyx_22051013_irq_sync u_ext_sync (
    .clk (clk),
    .rst (rst),
    .d   (irq_ext),
    .q   (irq_ext_p2)
  );

  // Single-flop capture of the timer and software interrupt levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_timer_p1 <= 1'b0;
      irq_soft_p1  <= 1'b0;
    end else begin
      irq_timer_p1 <= irq_timer;
      irq_soft_p1  <= irq_soft;
    end
  end

  assign mip      = {irq_ext_p2, 3'b000, irq_timer_p1, 3'b000, irq_soft_p1, 3'b000};
  assign irq_pend = mie_q & mip;

  // mstatus view: only MIE/MPIE are stored, MPP is fixed at machine mode.
  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MIE]  = mstatus_mie;
    mstatus_rd[MSTATUS_MPIE] = mstatus_mpie;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  // Address decode and old-value mux.
  always_comb begin
    csr_old = '0;
    csr_hit = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:  csr_old = mstatus_rd;
      CSR_MIE:      csr_old = {{(XLEN-12){1'b0}}, mie_q};
      CSR_MTVEC:    csr_old = mtvec_q;
      CSR_MSCRATCH: csr_old = mscratch_q;
      CSR_MEPC:     csr_old = mepc_q;
      CSR_MCAUSE:   csr_old = mcause_q;
      CSR_MTVAL:    csr_old = mtval_q;
      CSR_MIP:      csr_old = {{(XLEN-12){1'b0}}, mip};
      CSR_MCYCLE:   csr_old = mcycle_q;
      CSR_MINSTRET: csr_old = minstret_q;
      default:      csr_hit = 1'b0;
    endcase
  end

  assign csr_rdata   = (op != CSR_OP_NONE) ? csr_old : '0;
  assign csr_illegal = (op != CSR_OP_NONE) && !csr_hit;

  // New value for RW / set / clear.
  always_comb begin
    csr_new = csr_old;
    case (op)
      CSR_OP_RW: csr_new = csr_wdata;
      CSR_OP_RS: csr_new = csr_old | csr_wdata;
      CSR_OP_RC: csr_new = csr_old & ~csr_wdata;
      default:   csr_new = csr_old;
    endcase
  end

  // Set/clear with a zero operand is a pure read; a trap kills the write.
  assign csr_wen = (op != CSR_OP_NONE) && csr_hit && !trap &&
                   !((op == CSR_OP_RS || op == CSR_OP_RC) && csr_wdata == '0);

  // Exception and interrupt cause selection, fixed priority.
  always_comb begin
    exc_cause = CAUSE_ECALL;
    if (exc_illegal)     exc_cause = CAUSE_ILLEGAL;
    else if (exc_ebreak) exc_cause = CAUSE_EBREAK;
    irq_cause = CAUSE_MTI;
    if (irq_pend[CAUSE_MEI])      irq_cause = CAUSE_MEI;
    else if (irq_pend[CAUSE_MSI]) irq_cause = CAUSE_MSI;
  end

  assign exc_any  = exc_illegal | exc_ebreak | exc_ecall;
  assign irq_take = int_ready && mstatus_mie && (irq_pend != 12'h000) && !exc_any;
  assign trap     = exc_any | irq_take;

  assign mcause_new = exc_any ? {{(XLEN-4){1'b0}}, exc_cause}
                              : {1'b1, {(XLEN-5){1'b0}}, irq_cause};
  assign trap_base  = mtvec_q & LOW2_CLR;
  assign trap_vec   = (VECTORED_EN && mtvec_q[1:0] == 2'b01 && irq_take)
                      ? trap_base + {{(XLEN-6){1'b0}}, irq_cause, 2'b00}
                      : trap_base;

  assign trap_valid = !rst && (trap || mret);
  assign trap_pc    = trap ? trap_vec : mepc_q;

  // Trap-related state: trap entry, then mret, then ordinary CSR writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
    end else if (trap) begin
      mepc_q       <= pc & LOW2_CLR;
      mcause_q     <= mcause_new;
      mtval_q      <= exc_any ? exc_tval : '0;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else begin
      if (mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (csr_wen && csr_addr == CSR_MSTATUS) begin
        mstatus_mie  <= csr_new[MSTATUS_MIE];
        mstatus_mpie <= csr_new[MSTATUS_MPIE];
      end
      if (csr_wen && csr_addr == CSR_MEPC)   mepc_q   <= csr_new & LOW2_CLR;
      if (csr_wen && csr_addr == CSR_MCAUSE) mcause_q <= csr_new;
      if (csr_wen && csr_addr == CSR_MTVAL)  mtval_q  <= csr_new;
    end
  end

  // Plain software-owned CSRs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST_VAL;
      mscratch_q <= '0;
    end else if (csr_wen) begin
      if (csr_addr == CSR_MIE)      mie_q      <= csr_new[11:0] & IRQ_MASK;
      if (csr_addr == CSR_MTVEC)    mtvec_q    <= VECTORED_EN ? csr_new : (csr_new & LOW2_CLR);
      if (csr_addr == CSR_MSCRATCH) mscratch_q <= csr_new;
    end
  end

  // Free-running counters; a same-cycle CSR write overrides the increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else if (HAS_COUNTERS) begin
      if (csr_wen && csr_addr == CSR_MCYCLE) mcycle_q <= csr_new;
      else                                   mcycle_q <= mcycle_q + ONE;
      if (csr_wen && csr_addr == CSR_MINSTRET) minstret_q <= csr_new;
      else if (instr_retire)                   minstret_q <= minstret_q + ONE;
    end
  end

endmodule

// File: tb/tb_ysyx_22051013_csr_trap.sv
// Directed bench for the CSR file / trap controller with hand-computed
// expected values, one task per scenario.
module tb_ysyx_22051013_csr_trap;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata, csr_rdata;
  logic        csr_illegal;
  logic        exc_ecall, exc_ebreak, exc_illegal;
  logic [63:0] exc_tval;
  logic        mret;
  logic [63:0] pc;
  logic        int_ready, instr_retire;
  logic        irq_timer, irq_soft, irq_ext;
  logic        trap_valid;
  logic [63:0] trap_pc;

  int total = 0;
  int bad   = 0;

  ysyx_22051013_csr_trap #(
    .XLEN(64), .RST_MTVEC(64'h8000_0000), .HAS_COUNTERS(1'b1), .VECTORED_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .exc_ecall(exc_ecall), .exc_ebreak(exc_ebreak), .exc_illegal(exc_illegal),
    .exc_tval(exc_tval), .mret(mret), .pc(pc), .int_ready(int_ready),
    .instr_retire(instr_retire), .irq_timer(irq_timer), .irq_soft(irq_soft),
    .irq_ext(irq_ext), .trap_valid(trap_valid), .trap_pc(trap_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Read a CSR without side effects (set with zero operand).
  task automatic rd(input logic [11:0] a, output logic [63:0] v);
    csr_op = 2'b10; csr_addr = a; csr_wdata = 64'h0;
    #1;
    v = csr_rdata;
    csr_op = 2'b00;
  endtask

  // One CSR op committed on the next posedge.
  task automatic csr_wr(input logic [1:0] o, input logic [11:0] a, input logic [63:0] d);
    csr_op = o; csr_addr = a; csr_wdata = d;
    @(posedge clk); #1;
    csr_op = 2'b00; csr_wdata = 64'h0;
  endtask

  task automatic test_reset();
    logic [63:0] v;
    rst = 1'b1; exc_ecall = 1'b1; mret = 1'b1;
    #2;
    total++; if (trap_valid !== 1'b0) begin bad++; $display("FAIL rst_trap_valid got=%b exp=0", trap_valid); end
    exc_ecall = 1'b0; mret = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    csr_wr(2'b01, 12'h340, 64'h55);
    repeat (49) @(posedge clk); #1;
    rd(12'hB00, v);
    total++; if (v !== 64'd50) begin bad++; $display("FAIL mcycle_50 got=%h exp=%h", v, 64'd50); end
    rst = 1'b1; exc_ecall = 1'b1;
    #1;
    rd(12'h340, v);
    total++; if (v !== 64'h0) begin bad++; $display("FAIL rst_mscratch got=%h exp=0", v); end
    rd(12'hB00, v);
    total++; if (v !== 64'h0) begin bad++; $display("FAIL rst_mcycle got=%h exp=0", v); end
    rd(12'h305, v);
    total++; if (v !== 64'h8000_0000) begin bad++; $display("FAIL rst_mtvec got=%h exp=%h", v, 64'h8000_0000); end
    rd(12'h300, v);
    total++; if (v !== 64'h1800) begin bad++; $display("FAIL rst_mstatus got=%h exp=%h", v, 64'h1800); end
    total++; if (trap_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_trap_valid got=%b exp=0", trap_valid); end
    exc_ecall = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_decode();
    csr_op = 2'b01; csr_addr = 12'h7C0; csr_wdata = 64'h1;
    #1;
    total++; if (csr_illegal !== 1'b1) begin bad++; $display("FAIL illegal_addr got=%b exp=1", csr_illegal); end
    total++; if (csr_rdata !== 64'h0) begin bad++; $display("FAIL illegal_rdata got=%h exp=0", csr_rdata); end
    csr_op = 2'b00; csr_addr = 12'h305;
    #1;
    total++; if (csr_rdata !== 64'h0 || csr_illegal !== 1'b0) begin
      bad++; $display("FAIL op_none got=%h/%b exp=0/0", csr_rdata, csr_illegal); end
    @(posedge clk); #1;
  endtask

  task automatic test_rs_rc();
    logic [63:0] v;
    csr_wr(2'b01, 12'h340, 64'hF0);
    csr_op = 2'b10; csr_addr = 12'h340; csr_wdata = 64'h0F; #1;
    total++; if (csr_rdata !== 64'hF0) begin bad++; $display("FAIL rs_old got=%h exp=%h", csr_rdata, 64'hF0); end
    @(posedge clk); #1; csr_op = 2'b00;
    rd(12'h340, v);
    total++; if (v !== 64'hFF) begin bad++; $display("FAIL rs_new got=%h exp=%h", v, 64'hFF); end
    csr_op = 2'b11; csr_addr = 12'h340; csr_wdata = 64'hF0; #1;
    total++; if (csr_rdata !== 64'hFF) begin bad++; $display("FAIL rc_old got=%h exp=%h", csr_rdata, 64'hFF); end
    @(posedge clk); #1; csr_op = 2'b00;
    rd(12'h340, v);
    total++; if (v !== 64'h0F) begin bad++; $display("FAIL rc_new got=%h exp=%h", v, 64'h0F); end
    csr_wr(2'b10, 12'h340, 64'h0);
    rd(12'h340, v);
    total++; if (v !== 64'h0F) begin bad++; $display("FAIL rs_zero got=%h exp=%h", v, 64'h0F); end
  endtask

  task automatic test_ecall();
    logic [63:0] v;
    csr_wr(2'b01, 12'h305, 64'h8000_1000);
    csr_wr(2'b10, 12'h300, 64'h8);
    pc = 64'h8000_0100; exc_tval = 64'h1234; exc_ecall = 1'b1;
    #1;
    total++; if (trap_valid !== 1'b1 || trap_pc !== 64'h8000_1000) begin
      bad++; $display("FAIL ecall_redirect got=%b/%h exp=1/%h", trap_valid, trap_pc, 64'h8000_1000); end
    @(posedge clk); #1;
    exc_ecall = 1'b0;
    rd(12'h341, v);
    total++; if (v !== 64'h8000_0100) begin bad++; $display("FAIL ecall_mepc got=%h exp=%h", v, 64'h8000_0100); end
    rd(12'h342, v);
    total++; if (v !== 64'd11) begin bad++; $display("FAIL ecall_mcause got=%h exp=%h", v, 64'd11); end
    rd(12'h300, v);
    total++; if (v !== 64'h1880) begin bad++; $display("FAIL ecall_mstatus got=%h exp=%h", v, 64'h1880); end
    rd(12'h343, v);
    total++; if (v !== 64'h1234) begin bad++; $display("FAIL ecall_mtval got=%h exp=%h", v, 64'h1234); end
  endtask

  task automatic test_mret();
    logic [63:0] v;
    mret = 1'b1;
    #1;
    total++; if (trap_valid !== 1'b1 || trap_pc !== 64'h8000_0100) begin
      bad++; $display("FAIL mret_redirect got=%b/%h exp=1/%h", trap_valid, trap_pc, 64'h8000_0100); end
    @(posedge clk); #1;
    mret = 1'b0;
    rd(12'h300, v);
    total++; if (v !== 64'h1888) begin bad++; $display("FAIL mret_mstatus got=%h exp=%h", v, 64'h1888); end
  endtask

  task automatic test_vectored_mei();
    logic [63:0] v;
    csr_wr(2'b01, 12'h305, 64'h8000_1001);
    csr_wr(2'b01, 12'h304, 64'h888);
    pc = 64'h8000_0200; irq_ext = 1'b1; int_ready = 1'b1;
    #1;
    total++; if (trap_valid !== 1'b0) begin bad++; $display("FAIL mei_sync0 got=%b exp=0", trap_valid); end
    @(posedge clk); #1;
    total++; if (trap_valid !== 1'b0) begin bad++; $display("FAIL mei_sync1 got=%b exp=0", trap_valid); end
    @(posedge clk); #1;
    total++; if (trap_valid !== 1'b1 || trap_pc !== 64'h8000_102C) begin
      bad++; $display("FAIL mei_redirect got=%b/%h exp=1/%h", trap_valid, trap_pc, 64'h8000_102C); end
    @(posedge clk); #1;
    int_ready = 1'b0; irq_ext = 1'b0;
    rd(12'h342, v);
    total++; if (v !== 64'h8000_0000_0000_000B) begin bad++; $display("FAIL mei_mcause got=%h exp=%h", v, 64'h8000_0000_0000_000B); end
    rd(12'h341, v);
    total++; if (v !== 64'h8000_0200) begin bad++; $display("FAIL mei_mepc got=%h exp=%h", v, 64'h8000_0200); end
    rd(12'h343, v);
    total++; if (v !== 64'h0) begin bad++; $display("FAIL mei_mtval got=%h exp=0", v); end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_priority();
    logic [63:0] v;
    irq_timer = 1'b1; irq_soft = 1'b1;
    csr_wr(2'b10, 12'h300, 64'h8);
    rd(12'h344, v);
    total++; if (v !== 64'h088) begin bad++; $display("FAIL mip_ts got=%h exp=%h", v, 64'h088); end
    int_ready = 1'b1;
    #1;
    total++; if (trap_valid !== 1'b1 || trap_pc !== 64'h8000_100C) begin
      bad++; $display("FAIL msi_redirect got=%b/%h exp=1/%h", trap_valid, trap_pc, 64'h8000_100C); end
    @(posedge clk); #1;
    int_ready = 1'b0;
    rd(12'h342, v);
    total++; if (v !== 64'h8000_0000_0000_0003) begin bad++; $display("FAIL msi_mcause got=%h exp=%h", v, 64'h8000_0000_0000_0003); end
  endtask

  task automatic test_simultaneous();
    logic [63:0] v;
    csr_wr(2'b10, 12'h300, 64'h8);
    exc_illegal = 1'b1; exc_tval = 64'hDEAD; pc = 64'h8000_0300; int_ready = 1'b1;
    csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 64'hAAAA;
    #1;
    total++; if (trap_valid !== 1'b1 || trap_pc !== 64'h8000_1000) begin
      bad++; $display("FAIL ill_redirect got=%b/%h exp=1/%h", trap_valid, trap_pc, 64'h8000_1000); end
    total++; if (csr_rdata !== 64'h0F) begin bad++; $display("FAIL ill_rdata got=%h exp=%h", csr_rdata, 64'h0F); end
    @(posedge clk); #1;
    exc_illegal = 1'b0; int_ready = 1'b0; csr_op = 2'b00; csr_wdata = 64'h0;
    rd(12'h340, v);
    total++; if (v !== 64'h0F) begin bad++; $display("FAIL ill_mscratch got=%h exp=%h", v, 64'h0F); end
    rd(12'h342, v);
    total++; if (v !== 64'd2) begin bad++; $display("FAIL ill_mcause got=%h exp=%h", v, 64'd2); end
    rd(12'h343, v);
    total++; if (v !== 64'hDEAD) begin bad++; $display("FAIL ill_mtval got=%h exp=%h", v, 64'hDEAD); end
    rd(12'h341, v);
    total++; if (v !== 64'h8000_0300) begin bad++; $display("FAIL ill_mepc got=%h exp=%h", v, 64'h8000_0300); end
    exc_ebreak = 1'b1; exc_ecall = 1'b1; mret = 1'b1; pc = 64'h8000_0400;
    #1;
    total++; if (trap_valid !== 1'b1 || trap_pc !== 64'h8000_1000) begin
      bad++; $display("FAIL trap_over_mret got=%b/%h exp=1/%h", trap_valid, trap_pc, 64'h8000_1000); end
    @(posedge clk); #1;
    exc_ebreak = 1'b0; exc_ecall = 1'b0; mret = 1'b0;
    rd(12'h342, v);
    total++; if (v !== 64'd3) begin bad++; $display("FAIL ebreak_mcause got=%h exp=%h", v, 64'd3); end
    irq_timer = 1'b0; irq_soft = 1'b0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_counters();
    logic [63:0] v;
    csr_wr(2'b01, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'hB00, v);
    total++; if (v !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL mcycle_wr got=%h exp=all-ones", v); end
    @(posedge clk); #1;
    rd(12'hB00, v);
    total++; if (v !== 64'h0) begin bad++; $display("FAIL mcycle_wrap got=%h exp=0", v); end
    instr_retire = 1'b1;
    csr_wr(2'b01, 12'hB02, 64'd5);
    rd(12'hB02, v);
    total++; if (v !== 64'd5) begin bad++; $display("FAIL minstret_wr got=%h exp=%h", v, 64'd5); end
    repeat (3) @(posedge clk); #1;
    instr_retire = 1'b0;
    @(posedge clk); #1;
    rd(12'hB02, v);
    total++; if (v !== 64'd8) begin bad++; $display("FAIL minstret_cnt got=%h exp=%h", v, 64'd8); end
  endtask

  initial begin
    rst = 1'b1; csr_op = 2'b00; csr_addr = 12'h0; csr_wdata = 64'h0;
    exc_ecall = 1'b0; exc_ebreak = 1'b0; exc_illegal = 1'b0; exc_tval = 64'h0;
    mret = 1'b0; pc = 64'h0; int_ready = 1'b0; instr_retire = 1'b0;
    irq_timer = 1'b0; irq_soft = 1'b0; irq_ext = 1'b0;
    test_reset();
    test_decode();
    test_rs_rc();
    test_ecall();
    test_mret();
    test_vectored_mei();
    test_priority();
    test_simultaneous();
    test_counters();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
